// File: rtl/puf_req_arbiter.sv
// Round-robin arbiter that shares one puf128 instance among NREQ requesters.
// Optional one-entry response cache enabled by defining PUF_ARB_CACHE_EN.
module puf_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023,
  parameter int RST_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   chal,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [127:0]         rsp_data,
  output logic                 rsp_err,
  input  logic                 rsp_ack,
  output logic                 busy,
  output logic                 puf_rst,
  output logic [15:0]          puf_c,
  input  logic [127:0]         puf_out,
  input  logic                 puf_done
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(RST_CYC + 1);
  localparam int CW = (TW > RW) ? TW : RW;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DELIVER} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NREQ-1:0]  sel_q, sel_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [15:0]      puf_c_q, puf_c_d;
  logic [127:0]     data_q, data_d;
  logic             err_q, err_d;

`ifdef PUF_ARB_CACHE_EN
  logic             hit_q, hit_d;
  logic             cache_vld_q, cache_vld_d;
  logic [15:0]      cache_chal_q, cache_chal_d;
  logic [127:0]     cache_data_q, cache_data_d;
`endif

  // Rotate requests so bit 0 is the pointer position, then take the first set bit.
  logic [2*NREQ-1:0] req_rot2;
  logic [NREQ-1:0]   req_rot;
  logic              win_found;
  logic [IW-1:0]     win_off;
  logic [IW:0]       win_sum;
  logic [IW-1:0]     win_idx;
  logic [NREQ-1:0]   win_oh;
  logic [16*NREQ-1:0] chal_sh;
  logic [15:0]       win_chal;

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_rot2  = {req, req} >> ptr_q;
    req_rot   = req_rot2[NREQ-1:0];
    win_found = 1'b0;
    win_off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_off   = IW'(k);
      end
    end
    win_sum  = {1'b0, ptr_q} + {1'b0, win_off};
    win_idx  = (win_sum >= (IW+1)'(NREQ)) ? IW'(win_sum - (IW+1)'(NREQ)) : IW'(win_sum);
    win_oh   = NREQ'(1) << win_idx;
    chal_sh  = chal >> {win_idx, 4'b0000};
    win_chal = chal_sh[15:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      puf_c_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      puf_c_q <= puf_c_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

`ifdef PUF_ARB_CACHE_EN
  // NOTE: only the valid bit needs reset; the stored challenge and response
  // are never observed while it is clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q       <= 1'b0;
      cache_vld_q <= 1'b0;
    end else begin
      hit_q       <= hit_d;
      cache_vld_q <= cache_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    cache_chal_q <= cache_chal_d;
    cache_data_q <= cache_data_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    gnt_d   = '0;
    puf_c_d = puf_c_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef PUF_ARB_CACHE_EN
    hit_d        = hit_q;
    cache_vld_d  = cache_vld_q;
    cache_chal_d = cache_chal_q;
    cache_data_d = cache_data_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_d   = win_oh;
          sel_d   = win_oh;
          idx_d   = win_idx;
          puf_c_d = win_chal;
          cnt_d   = '0;
          state_d = S_START;
`ifdef PUF_ARB_CACHE_EN
          hit_d   = cache_vld_q && (cache_chal_q == win_chal);
`endif
        end
      end
      S_START: begin
`ifdef PUF_ARB_CACHE_EN
        // A hit skips the PUF entirely; puf_rst never drops.
        if (hit_q) begin
          data_d  = cache_data_q;
          err_d   = 1'b0;
          state_d = S_DELIVER;
        end else
`endif
        if (cnt_q == CW'(RST_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (puf_done) begin
          data_d  = puf_out;
          err_d   = 1'b0;
          state_d = S_DELIVER;
`ifdef PUF_ARB_CACHE_EN
          cache_vld_d  = 1'b1;
          cache_chal_d = puf_c_q;
          cache_data_d = puf_out;
`endif
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (rsp_ack) begin
          ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b1;
    puf_rst   = 1'b1;
    rsp_valid = '0;
    case (state_q)
      S_IDLE:    busy = 1'b0;
      S_START:   ;
      S_WAIT:    puf_rst = 1'b0;
      S_DELIVER: rsp_valid = sel_q;
      default:   busy = 1'b0;
    endcase
  end

  assign gnt      = gnt_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;
  assign puf_c    = puf_c_q;

endmodule

// File: tb/tb_puf_req_arbiter.sv
// Scoreboard bench for puf_req_arbiter with a small puf128 behavioural model.
module tb_puf_req_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;
  localparam int RST_CYC = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  chal;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [127:0]        rsp_data;
  logic                rsp_err;
  logic                rsp_ack;
  logic                busy;
  logic                puf_rst;
  logic [15:0]         puf_c;
  logic [127:0]        puf_out;
  logic                puf_done;

  puf_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .RST_CYC(RST_CYC)) dut (
    .clk(clk), .rst(rst), .req(req), .chal(chal), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ack(rsp_ack), .busy(busy), .puf_rst(puf_rst), .puf_c(puf_c),
    .puf_out(puf_out), .puf_done(puf_done)
  );

  always #5 clk = ~clk;

  // PUF model: done fires done_dly cycles after puf_rst falls; response derived from C.
  int wcnt = 0;
  int done_dly = 5;
  bit done_en = 1'b1;

  function automatic logic [127:0] puf_fn(input logic [15:0] c);
    return {8{c ^ 16'hB791}};
  endfunction

  always @(posedge clk) begin
    if (puf_rst) wcnt <= 0;
    else         wcnt <= wcnt + 1;
  end

  assign puf_done = done_en && !puf_rst && (wcnt == done_dly);
  assign puf_out  = puf_done ? puf_fn(puf_c) : '0;

  typedef struct { logic [NREQ-1:0] oh; logic [15:0] c; } gnt_t;
  typedef struct { logic [NREQ-1:0] oh; logic [127:0] d; logic e; } rsp_t;
  gnt_t gq[$];
  rsp_t rq[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare each grant pulse and each new response against the queues.
  logic [NREQ-1:0] prev_valid = '0;
  always @(negedge clk) begin
    gnt_t g;
    rsp_t r;
    if (gnt != '0) begin
      if (gq.size() == 0) check("gnt_unexpected", 128'(gnt), 128'(0));
      else begin
        g = gq.pop_front();
        check("gnt_onehot", 128'(gnt), 128'(g.oh));
        check("gnt_puf_c", 128'(puf_c), 128'(g.c));
      end
    end
    if (rsp_valid != '0 && prev_valid == '0) begin
      if (rq.size() == 0) check("rsp_unexpected", 128'(rsp_valid), 128'(0));
      else begin
        r = rq.pop_front();
        check("rsp_valid_onehot", 128'(rsp_valid), 128'(r.oh));
        check("rsp_data", rsp_data, r.d);
        check("rsp_err", 128'(rsp_err), 128'(r.e));
      end
    end
    prev_valid = rsp_valid;
  end

  task automatic expect_op(input logic [NREQ-1:0] oh, input logic [15:0] c,
                           input logic [127:0] d, input logic e);
    gq.push_back('{oh, c});
    rq.push_back('{oh, d, e});
  endtask

  task automatic wait_valid();
    int n = 0;
    while (rsp_valid == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_seen", 128'(|rsp_valid), 128'(1));
  endtask

  task automatic wait_puf_run();
    int n = 0;
    while (puf_rst && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("puf_rst_released", 128'(puf_rst), 128'(0));
  endtask

  task automatic do_ack(input logic [NREQ-1:0] drop);
    rsp_ack = 1'b1;
    @(negedge clk);
    rsp_ack = 1'b0;
    req = req & ~drop;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [15:0]  chal_tab [NREQ];
  logic [127:0] resp_tab [NREQ];

  initial begin
    int n;
    logic [1:0] ri;
    chal_tab = '{16'h1234, 16'h0F0F, 16'hCAFE, 16'h5A5A};
    resp_tab = '{{8{16'hA5A5}}, {8{16'hB89E}}, {8{16'h7D6F}}, {8{16'hEDCB}}};
    chal = {chal_tab[3], chal_tab[2], chal_tab[1], chal_tab[0]};
    rst = 1'b1; req = '0; rsp_ack = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_gnt", 128'(gnt), 128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_data", rsp_data, 128'(0));
    check("rst_rsp_err", 128'(rsp_err), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_puf_rst", 128'(puf_rst), 128'(1));
    check("rst_puf_c", 128'(puf_c), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Single request with cycle-accurate latency checks.
    expect_op(4'b0001, 16'h1234, {8{16'hA5A5}}, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    check("lat_c1_gnt", 128'(gnt), 128'(4'b0001));
    check("lat_c1_puf_rst", 128'(puf_rst), 128'(1));
    check("lat_c1_busy", 128'(busy), 128'(1));
    @(negedge clk);
    check("lat_c2_gnt", 128'(gnt), 128'(0));
    check("lat_c2_puf_rst", 128'(puf_rst), 128'(1));
    @(negedge clk);
    check("lat_c3_puf_rst", 128'(puf_rst), 128'(0));
    wait_valid();
    do_ack(4'b0001);
    check("idle_busy", 128'(busy), 128'(0));
    check("idle_rsp_valid", 128'(rsp_valid), 128'(0));
    check("idle_puf_c_held", 128'(puf_c), 128'(16'h1234));

    // Round robin from pointer 0 with all requests held.
    pulse_rst();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      ri = 2'(k % 4);
      expect_op(4'b0001 << ri, chal_tab[ri], resp_tab[ri], 1'b0);
      wait_valid();
      do_ack(k == 4 ? 4'b1111 : 4'b0000);
    end

    // Timeout: pointer is 1, so requester 2 wins; no puf_done ever.
    done_en = 1'b0;
    expect_op(4'b0100, 16'hCAFE, 128'(0), 1'b1);
    req = 4'b0100;
    @(negedge clk);
    wait_puf_run();
    n = 0;
    while (rsp_valid == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_wait_cycles", 128'(n), 128'(15));
    do_ack(4'b0100);
    done_en = 1'b1;
    expect_op(4'b1000, 16'h5A5A, {8{16'hEDCB}}, 1'b0);
    req = 4'b1000;
    wait_valid();
    do_ack(4'b1000);

    // puf_done on the very cycle the timeout would fire.
    done_dly = 14;
    expect_op(4'b0001, 16'h1234, {8{16'hA5A5}}, 1'b0);
    req = 4'b0001;
    wait_valid();
    do_ack(4'b0001);
    done_dly = 5;

    // rsp_ack outside DELIVER has no effect.
    expect_op(4'b0010, 16'h0F0F, {8{16'hB89E}}, 1'b0);
    req = 4'b0010;
    repeat (4) @(negedge clk);
    rsp_ack = 1'b1;
    @(negedge clk);
    rsp_ack = 1'b0;
    wait_valid();
    do_ack(4'b0010);

    // Reset mid-WAIT aborts; pointer (2 before) returns to 0.
    gq.push_back('{4'b1000, 16'h5A5A});
    req = 4'b1000;
    @(negedge clk);
    wait_puf_run();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_rsp_valid", 128'(rsp_valid), 128'(0));
    check("abort_puf_rst", 128'(puf_rst), 128'(1));
    expect_op(4'b0001, 16'h1234, {8{16'hA5A5}}, 1'b0);
    expect_op(4'b0100, 16'hCAFE, {8{16'h7D6F}}, 1'b0);
    req = 4'b0101;
    wait_valid();
    do_ack(4'b0001);
    wait_valid();
    do_ack(4'b0100);

`ifdef PUF_ARB_CACHE_EN
    // Cache: repeated challenge skips the PUF, a new one runs it.
    pulse_rst();
    chal[15:0] = 16'hBEEF;
    expect_op(4'b0001, 16'hBEEF, {8{16'h097E}}, 1'b0);
    req = 4'b0001;
    wait_valid();
    do_ack(4'b0001);
    expect_op(4'b0001, 16'hBEEF, {8{16'h097E}}, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    check("cache_c1_puf_rst", 128'(puf_rst), 128'(1));
    @(negedge clk);
    check("cache_c2_rsp_valid", 128'(rsp_valid), 128'(4'b0001));
    check("cache_c2_puf_rst", 128'(puf_rst), 128'(1));
    do_ack(4'b0001);
    chal[15:0] = 16'hBEF0;
    expect_op(4'b0001, 16'hBEF0, {8{16'h0961}}, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    wait_puf_run();
    wait_valid();
    do_ack(4'b0001);
`endif

    repeat (3) @(negedge clk);
    check("gnt_queue_drained", 128'(gq.size()), 128'(0));
    check("rsp_queue_drained", 128'(rq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
